// File: rtl/hdmi_clk_pkg.sv
// Shared types and default timing constants for the HDMI output clocking reset sequence.
// Pure declarations: no latency, no flow control.
package hdmi_clk_pkg;

   typedef enum logic [2:0] {
      RST_MMCM,
      WAIT_LOCK,
      HOLD_SERDES,
      DELAY_CORE,
      RUN
   } seq_state_t;

   localparam int DEF_MMCM_RST_CYCLES     = 16;
   localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
   localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
   localparam int DEF_SERDES_HOLD_CYCLES  = 16;
   localparam int DEF_CORE_DELAY_CYCLES   = 8;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/hdmi_reset_sequencer_if.sv
// Lock input and reset outputs between the sequencer (master) and the HDMI datapath (slave).
// Plain wires: no latency, no flow control.
interface hdmi_reset_sequencer_if;
   logic locked;
   logic mmcm_reset;
   logic serdes_reset;
   logic core_resetn;
   logic ready;

   modport master (
      input  locked,
      output mmcm_reset,
      output serdes_reset,
      output core_resetn,
      output ready
   );

   modport slave (
      output locked,
      input  mmcm_reset,
      input  serdes_reset,
      input  core_resetn,
      input  ready
   );
endinterface

// File: rtl/sync_bit.sv
// N-flop single-bit synchronizer for asynchronous inputs; N >= 2.
// Latency N clk cycles; synchronous active-low reset clears the chain to 0.
module sync_bit #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic d,
   output logic q
);

   logic [N-1:0] sr;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         sr <= '0;
      end else begin
         sr <= {sr[N-2:0], d};
      end
   end

   assign q = sr[N-1];

endmodule

// File: rtl/hdmi_reset_sequencer.sv
// Pulses the MMCM reset, qualifies lock, then releases OSERDES and encoder core resets in order.
// Outputs registered from next state; lock loss reaches the outputs 3 edges after locked falls.
module hdmi_reset_sequencer
   import hdmi_clk_pkg::*;
#(
   parameter int MMCM_RST_CYCLES     = DEF_MMCM_RST_CYCLES,
   parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
   parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
   parameter int SERDES_HOLD_CYCLES  = DEF_SERDES_HOLD_CYCLES,
   parameter int CORE_DELAY_CYCLES   = DEF_CORE_DELAY_CYCLES
) (
   input  logic                   clk,
   input  logic                   resetn,
   hdmi_reset_sequencer_if.master rst_if
);

   localparam int CNT_MAX = max4(MMCM_RST_CYCLES, LOCK_STABLE_CYCLES,
                                 SERDES_HOLD_CYCLES, CORE_DELAY_CYCLES);
   localparam int CW = $clog2(CNT_MAX + 1);
   localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);

   localparam logic [CW-1:0] MMCM_LAST    = CW'(MMCM_RST_CYCLES - 1);
   localparam logic [CW-1:0] LOCK_LAST    = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0] SERDES_LAST  = CW'(SERDES_HOLD_CYCLES - 1);
   localparam logic [CW-1:0] CORE_LAST    = CW'(CORE_DELAY_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);

   seq_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          locked_s;
   logic          mmcm_reset_q, serdes_reset_q, core_resetn_q, ready_q;

   sync_bit #(.N(2)) u_lock_sync (
      .clk    (clk),
      .resetn (resetn),
      .d      (rst_if.locked),
      .q      (locked_s)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tcnt_d  = tcnt_q;
      unique case (state_q)
         RST_MMCM: begin
            if (cnt_q == MMCM_LAST) begin
               cnt_d   = '0;
               tcnt_d  = '0;
               state_d = WAIT_LOCK;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_LOCK: begin
            tcnt_d = tcnt_q + 1'b1;
            cnt_d  = locked_s ? cnt_q + 1'b1 : '0;
            // A lock that qualifies on the timeout cycle wins over re-pulsing the MMCM.
            if (locked_s && cnt_q == LOCK_LAST) begin
               cnt_d   = '0;
               state_d = HOLD_SERDES;
            end else if (tcnt_q == TIMEOUT_LAST) begin
               cnt_d   = '0;
               state_d = RST_MMCM;
            end
         end
         HOLD_SERDES, DELAY_CORE: begin
            if (!locked_s) begin
               cnt_d   = '0;
               state_d = RST_MMCM;
            end else if (cnt_q == ((state_q == HOLD_SERDES) ? SERDES_LAST : CORE_LAST)) begin
               cnt_d   = '0;
               state_d = (state_q == HOLD_SERDES) ? DELAY_CORE : RUN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RUN: begin
            if (!locked_s) begin
               cnt_d   = '0;
               state_d = RST_MMCM;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = RST_MMCM;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q        <= RST_MMCM;
         cnt_q          <= '0;
         tcnt_q         <= '0;
         mmcm_reset_q   <= 1'b1;
         serdes_reset_q <= 1'b1;
         core_resetn_q  <= 1'b0;
         ready_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         tcnt_q         <= tcnt_d;
         mmcm_reset_q   <= (state_d == RST_MMCM);
         serdes_reset_q <= (state_d == RST_MMCM) || (state_d == WAIT_LOCK) ||
                           (state_d == HOLD_SERDES);
         core_resetn_q  <= (state_d == RUN);
         ready_q        <= (state_d == RUN);
      end
   end

   assign rst_if.mmcm_reset   = mmcm_reset_q;
   assign rst_if.serdes_reset = serdes_reset_q;
   assign rst_if.core_resetn  = core_resetn_q;
   assign rst_if.ready        = ready_q;

endmodule

// File: tb/tb_hdmi_reset_sequencer.sv
// Directed bench for hdmi_reset_sequencer with M=4, L=8, S=4, C=2, timeout=64.
// Output vector compared each edge is {mmcm_reset, serdes_reset, core_resetn, ready}.
module tb_hdmi_reset_sequencer;

   logic clk = 1'b0;
   logic resetn;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [3:0] got, exp;

   hdmi_reset_sequencer_if rif ();

   hdmi_reset_sequencer #(
      .MMCM_RST_CYCLES     (4),
      .LOCK_STABLE_CYCLES  (8),
      .LOCK_TIMEOUT_CYCLES (64),
      .SERDES_HOLD_CYCLES  (4),
      .CORE_DELAY_CYCLES   (2)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .rst_if (rif.master)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      got = {rif.mmcm_reset, rif.serdes_reset, rif.core_resetn, rif.ready};
   endtask

   // After this returns, the next rising edge is edge 1.
   task automatic do_reset(input logic lk);
      resetn     = 1'b0;
      rif.locked = lk;
      repeat (3) tick();
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      do_reset(1'b1);
      n_tests++;
      if (rif.mmcm_reset !== 1'b1) begin
         n_fail++; $display("FAIL reset_mmcm: got %b want 1", rif.mmcm_reset);
      end
      n_tests++;
      if (rif.serdes_reset !== 1'b1) begin
         n_fail++; $display("FAIL reset_serdes: got %b want 1", rif.serdes_reset);
      end
      n_tests++;
      if (rif.core_resetn !== 1'b0) begin
         n_fail++; $display("FAIL reset_core: got %b want 0", rif.core_resetn);
      end
      n_tests++;
      if (rif.ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_ready: got %b want 0", rif.ready);
      end
   endtask

   task automatic test_normal();
      do_reset(1'b1);
      for (int e = 1; e <= 24; e++) begin
         tick();
         exp = {e < 4, e < 16, e >= 18, e >= 18};
         n_tests++;
         if (got !== exp) begin
            n_fail++; $display("FAIL normal edge %0d: got %b want %b", e, got, exp);
         end
      end
   endtask

   // Continues from RUN left by test_normal.
   task automatic test_lock_loss_run();
      rif.locked = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         exp = (k < 3) ? 4'b0011 : 4'b1100;
         n_tests++;
         if (got !== exp) begin
            n_fail++; $display("FAIL lockloss edge +%0d: got %b want %b", k, got, exp);
         end
      end
      rif.locked = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         tick();
         exp = {e < 4, e < 16, e >= 18, e >= 18};
         n_tests++;
         if (got !== exp) begin
            n_fail++; $display("FAIL lockloss_replay edge %0d: got %b want %b", e, got, exp);
         end
      end
   endtask

   task automatic test_lock_glitch();
      do_reset(1'b1);
      for (int e = 1; e <= 26; e++) begin
         rif.locked = (e != 8);
         tick();
         exp = {e < 4, e < 22, e >= 24, e >= 24};
         n_tests++;
         if (got !== exp) begin
            n_fail++; $display("FAIL glitch edge %0d: got %b want %b", e, got, exp);
         end
      end
   endtask

   task automatic test_lock_stuck();
      do_reset(1'b0);
      for (int e = 1; e <= 150; e++) begin
         tick();
         exp = {(e < 4) || (e >= 68 && e < 72) || (e >= 136 && e < 140), 3'b100};
         n_tests++;
         if (got !== exp) begin
            n_fail++; $display("FAIL stuck edge %0d: got %b want %b", e, got, exp);
         end
      end
   endtask

   task automatic test_reset_pulse();
      do_reset(1'b1);
      for (int e = 1; e <= 16; e++) begin
         tick();
         exp = {e < 4, e < 16, 2'b00};
         n_tests++;
         if (got !== exp) begin
            n_fail++; $display("FAIL rpulse_pre edge %0d: got %b want %b", e, got, exp);
         end
      end
      resetn = 1'b0;
      tick();
      n_tests++;
      if (got !== 4'b1100) begin
         n_fail++; $display("FAIL rpulse_reset: got %b want 1100", got);
      end
      resetn = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         tick();
         exp = {e < 4, e < 16, e >= 18, e >= 18};
         n_tests++;
         if (got !== exp) begin
            n_fail++; $display("FAIL rpulse_replay edge %0d: got %b want %b", e, got, exp);
         end
      end
   endtask

   // Lock sampled from edge 59 makes cnt hit 7 exactly when tcnt hits 63 (edge 68).
   task automatic test_qual_vs_timeout();
      do_reset(1'b0);
      for (int e = 1; e <= 80; e++) begin
         rif.locked = (e >= 59);
         tick();
         exp = {e < 4, e < 72, e >= 74, e >= 74};
         n_tests++;
         if (got !== exp) begin
            n_fail++; $display("FAIL qual_timeout edge %0d: got %b want %b", e, got, exp);
         end
      end
   endtask

   initial begin
      resetn     = 1'b0;
      rif.locked = 1'b0;
      test_reset();
      test_normal();
      test_lock_loss_run();
      test_lock_glitch();
      test_lock_stuck();
      test_reset_pulse();
      test_qual_vs_timeout();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
